mem_ram_responder: RTL and testbench

//  Memory-side responder for the MEM-stage RAM request (read/write enable, word address, byte select, write data).

---
 rtl/mem_ram_responder_pkg.sv | 31 +++
 rtl/mem_ram_responder_if.sv | 38 +++
 rtl/mem_ram_responder.sv | 133 +++++++++++++
 tb/tb_mem_ram_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_ram_responder_pkg.sv
// Purpose: shared types and constants for the MEM-stage RAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_ram_responder_pkg;

   localparam int MEM_ADDR_W      = 32;
   localparam int MEM_ADDR_HIGH_W = MEM_ADDR_W - 2;
   localparam int MEM_SEL_W       = 4;
   localparam int MEM_WORD_W      = 32;

   typedef logic [MEM_SEL_W-1:0]       mem_sel_bus_t;
   typedef logic [MEM_ADDR_HIGH_W-1:0] mem_addr_high_bus_t;

   localparam logic [MEM_WORD_W-1:0] ZERO_WORD = '0;

   // Responder FSM: BUSY walks the four byte lanes, TAIL waits out the
   // read latency of the last lane, DONE pulses the response.
   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_BUSY = 2'd1,
      RSP_TAIL = 2'd2,
      RSP_DONE = 2'd3
   } rsp_state_e;

   // Pick byte lane 'lane' out of a 32-bit word.
   function automatic logic [7:0] word_byte(input logic [MEM_WORD_W-1:0] w,
                                            input logic [1:0]            lane);
      return w[8*lane +: 8];
   endfunction

endpackage

// File: rtl/mem_ram_responder_if.sv
// Purpose: pipeline-request / response / byte-SRAM bundle for the RAM responder.
// Latency: n/a (wires only).
// Backpressure: stall_o holds the pipeline request; SRAM side has none.
interface mem_ram_responder_if #(
   parameter int ADDR_W = 32
);
   // pipeline request (from EX/MEM register)
   logic              req_read;
   logic              req_write;
   logic [ADDR_W-3:0] req_addr;
   logic [3:0]        req_sel;
   logic [31:0]       req_wdata;
   // pipeline response
   logic              stall_o;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   // byte-wide synchronous SRAM
   logic              sram_en;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [7:0]        sram_wdata;
   logic [7:0]        sram_rdata;

   // responder view
   modport slave (
      input  req_read, req_write, req_addr, req_sel, req_wdata, sram_rdata,
      output stall_o, resp_valid, resp_rdata,
      output sram_en, sram_we, sram_addr, sram_wdata
   );

   // pipeline + SRAM view
   modport master (
      output req_read, req_write, req_addr, req_sel, req_wdata, sram_rdata,
      input  stall_o, resp_valid, resp_rdata,
      input  sram_en, sram_we, sram_addr, sram_wdata
   );

endinterface

// File: rtl/mem_ram_responder.sv
// Purpose: serialise a word RAM request into four byte accesses on a byte-wide SRAM.
// Latency: write response 5 cycles, read response 6 cycles after the request is seen.
// Backpressure: stall_o holds the pipeline until the response cycle; fixed latency.
module mem_ram_responder
   import mem_ram_responder_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_ram_responder_if.slave    bus
);

   rsp_state_e        state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [ADDR_W-3:0] addr_q, addr_d;
   mem_sel_bus_t      sel_q, sel_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [31:0]       rdata_q, rdata_d;
   // a read byte issued in lane cap_lane_q arrives on sram_rdata this cycle
   logic              cap_vld_q, cap_vld_d;
   logic [1:0]        cap_lane_q, cap_lane_d;

   logic              req_active;
   logic              stall;
   logic              resp_vld;
   logic              en;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wbyte;

   // A request with no lanes selected is a no-op and never stalls.
   assign req_active = (bus.req_read | bus.req_write) & (bus.req_sel != '0);

   // State, lane counter and latched request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RSP_IDLE;
         lane_q     <= 2'd0;
         addr_q     <= '0;
         sel_q      <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         rdata_q    <= ZERO_WORD;
         cap_vld_q  <= 1'b0;
         cap_lane_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         rdata_q    <= rdata_d;
         cap_vld_q  <= cap_vld_d;
         cap_lane_q <= cap_lane_d;
      end
   end

   // Next-state, read-byte capture and SRAM/pipeline output decode.
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      rdata_d    = rdata_q;
      cap_vld_d  = 1'b0;
      cap_lane_d = lane_q;
      stall      = 1'b0;
      resp_vld   = 1'b0;
      en         = 1'b0;
      we         = 1'b0;
      addr       = '0;
      wbyte      = 8'h00;

      if (cap_vld_q) begin
         rdata_d[8*cap_lane_q +: 8] = bus.sram_rdata;
      end

      case (state_q)
         RSP_IDLE: begin
            stall = req_active;
            if (req_active) begin
               addr_d  = bus.req_addr;
               sel_d   = bus.req_sel;
               wdata_d = bus.req_wdata;
               wr_d    = bus.req_write;   // write wins when both are set
               rdata_d = ZERO_WORD;
               lane_d  = 2'd0;
               state_d = RSP_BUSY;
            end
         end
         RSP_BUSY: begin
            stall      = 1'b1;
            en         = sel_q[lane_q];
            we         = wr_q;
            addr       = {addr_q, lane_q};
            wbyte      = word_byte(wdata_q, lane_q);
            cap_vld_d  = ~wr_q & sel_q[lane_q];
            cap_lane_d = lane_q;
            lane_d     = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
               state_d = wr_q ? RSP_DONE : RSP_TAIL;
            end
         end
         RSP_TAIL: begin
            stall   = 1'b1;
            state_d = RSP_DONE;
         end
         RSP_DONE: begin
            resp_vld = 1'b1;
            state_d  = RSP_IDLE;
         end
         default: begin
            state_d = RSP_IDLE;
         end
      endcase
   end

   // While rst is held nothing reaches the SRAM or the pipeline, so a
   // reset during a write stops it at the current lane.
   assign bus.stall_o    = stall & ~rst;
   assign bus.resp_valid = resp_vld & ~rst;
   assign bus.resp_rdata = rdata_q;
   assign bus.sram_en    = en & ~rst;
   assign bus.sram_we    = we & ~rst;
   assign bus.sram_addr  = rst ? '0 : addr;
   assign bus.sram_wdata = rst ? 8'h00 : wbyte;

endmodule

// File: tb/tb_mem_ram_responder.sv
// Purpose: directed bench for mem_ram_responder with a byte SRAM model.
// Latency: checks write response at cycle 5, read response at cycle 6.
// Backpressure: checks stall_o on every cycle of each access.
module tb_mem_ram_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_clr = 1'b1;

   int n_vec = 0;
   int n_bad = 0;

   mem_ram_responder_if #(.ADDR_W(32)) bus ();

   mem_ram_responder #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // byte SRAM model, 1-cycle read latency
   logic [7:0] mem [0:4095];
   logic [7:0] rd_q = 8'h00;
   assign bus.sram_rdata = rd_q;

   // SRAM write / read port, with a bulk clear used at start-up
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      end else if (bus.sram_en) begin
         if (bus.sram_we) mem[bus.sram_addr[11:0]] <= bus.sram_wdata;
         else             rd_q <= mem[bus.sram_addr[11:0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [11:0] base);
      return {mem[base+3], mem[base+2], mem[base+1], mem[base]};
   endfunction

   // Present a request after the next edge and follow it to its response.
   // The request stays on the bus afterwards; caller drops or replaces it.
   task automatic do_req(input string tag, input logic rd, input logic wr,
                         input logic [29:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input int exp_lat,
                         input int exp_strb, input logic [31:0] exp_rd);
      int  c       = 0;
      int  strb    = 0;
      int  nostall = 0;
      bit  done    = 1'b0;
      @(posedge clk); #1;
      bus.req_read  = rd;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_sel   = sel;
      bus.req_wdata = wd;
      while (!done && c < 20) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            chk({tag, "_lat"},      c,              exp_lat);
            chk({tag, "_rdata"},    bus.resp_rdata, exp_rd);
            chk({tag, "_donestl"},  bus.stall_o,    1'b0);
            done = 1'b1;
         end else begin
            if (!bus.stall_o) nostall++;
            if (bus.sram_en)  strb++;
            c++;
         end
      end
      if (!done) chk({tag, "_timeout"}, 0, 1);
      chk({tag, "_strobes"}, strb,    exp_strb);
      chk({tag, "_stall"},   nostall, 0);
   endtask

   task automatic idle_bus();
      @(posedge clk); #1;
      bus.req_read  = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_sel   = 4'h0;
      bus.req_wdata = '0;
   endtask

   initial begin
      int s_stall;
      int s_en;
      bus.req_read  = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_sel   = 4'h0;
      bus.req_wdata = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", bus.stall_o,    1'b0);
      chk("rst_resp",  bus.resp_valid, 1'b0);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_en",    bus.sram_en,    1'b0);
      chk("rst_addr",  bus.sram_addr,  32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      mem_clr = 1'b0;

      // full write then full read
      do_req("wr_full", 1'b0, 1'b1, 30'h100, 4'hF, 32'hA1B2C3D4, 5, 4, 32'h0);
      idle_bus();
      chk("wr_full_mem", mem_word(12'h400), 32'hA1B2C3D4);
      do_req("rd_full", 1'b1, 1'b0, 30'h100, 4'hF, 32'h0, 6, 4, 32'hA1B2C3D4);
      idle_bus();
      @(negedge clk);
      chk("resp_pulse", bus.resp_valid, 1'b0);
      chk("rdata_hold", bus.resp_rdata, 32'hA1B2C3D4);

      // partial write of lane 2, partial read of lanes 1-2
      do_req("wr_part", 1'b0, 1'b1, 30'h100, 4'b0100, 32'h00EE0000, 5, 1, 32'h0);
      idle_bus();
      chk("wr_part_mem", mem_word(12'h400), 32'hA1EEC3D4);
      do_req("rd_part", 1'b1, 1'b0, 30'h100, 4'b0110, 32'h0, 6, 2, 32'h00EEC300);
      idle_bus();

      // read with no lanes selected is ignored
      bus.req_read = 1'b1;
      bus.req_addr = 30'h100;
      s_stall = 0;
      s_en    = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.stall_o) s_stall++;
         if (bus.sram_en || bus.resp_valid) s_en++;
      end
      chk("sel0_stall", s_stall, 0);
      chk("sel0_traffic", s_en, 0);
      idle_bus();

      // read and write together performs the write
      do_req("rdwr", 1'b1, 1'b1, 30'h101, 4'hF, 32'h55667788, 5, 4, 32'h0);
      idle_bus();
      chk("rdwr_mem", mem_word(12'h404), 32'h55667788);

      // back-to-back: second request accepted the cycle after DONE
      do_req("b2b_wr", 1'b0, 1'b1, 30'h102, 4'b0011, 32'h0000BEEF, 5, 2, 32'h0);
      do_req("b2b_rd", 1'b1, 1'b0, 30'h102, 4'hF, 32'h0, 6, 4, 32'h0000BEEF);
      idle_bus();

      // reset during lane 2 of a write
      @(posedge clk); #1;
      bus.req_write = 1'b1;
      bus.req_addr  = 30'h103;
      bus.req_sel   = 4'hF;
      bus.req_wdata = 32'h11223344;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_lane1_addr", bus.sram_addr, 32'h40D);
      @(posedge clk); #1;
      rst = 1'b1;
      bus.req_write = 1'b0;
      bus.req_sel   = 4'h0;
      @(negedge clk);
      chk("mid_rst_en", bus.sram_en, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_stall", bus.stall_o,    1'b0);
      chk("post_rst_en",    bus.sram_en,    1'b0);
      chk("post_rst_resp",  bus.resp_valid, 1'b0);
      chk("post_rst_rdata", bus.resp_rdata, 32'h0);
      chk("post_rst_mem",   mem_word(12'h40C), 32'h00003344);
      do_req("post_rst_rd", 1'b1, 1'b0, 30'h103, 4'hF, 32'h0, 6, 4, 32'h00003344);
      idle_bus();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
